bz_deserializer_rr: RTL and testbench
=====================================

Name: bz_deserializer_rr

Overview:
- Next-generation BZ flit deserializer: reassembles wormhole packets of (NBDdata+1)-bit flits from NUM_IN show-ahead FIFOs into one (NPCcode+NPCdata)-bit word for the PC-bound Channel.
- Adds packet-granular round-robin arbitration across inputs, short-packet zero-extension, and overlong-packet detection with drain.
- Adds a double-buffered output so assembly of packet N+1 overlaps the handshake of packet N.

Parameters:
- NPCcode, 8, code field width of output word
- NPCdata, 24, data field width of output word
- NBDdata, 10, payload bits per flit; the flit's MSB (bit NBDdata) is the tail bit
- NUM_IN, 2, number of input FIFOs, 1..16
- NERR, 16, error counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- isempty  in  NUM_IN  per-FIFO empty flag
- data_in  in  NUM_IN x (NBDdata+1)  per-FIFO head flit {tail, payload}; show-ahead, valid while !isempty
- rdreq  out  NUM_IN  per-FIFO pop, one-hot or zero
- PC_out_channel  Channel  NPCcode+NPCdata  output v/a/d channel (v, d driven; a received)
- PC_out_src  out  $clog2(NUM_IN) (min 1)  source lane of d, stable while v=1
- err_pulse  out  1  one-cycle pulse on overlong-packet detection
- err_count  out  NERR  saturating count of overlong packets

Behaviour:
- Constants: W = NPCcode+NPCdata; NFLITS = ceil(W/NBDdata), 4 at defaults. Flit k (0-based) payload is placed at bits [k*NBDdata +: NBDdata]; bits at or above W are discarded.
- Reset values: rdreq=0, v=0, d=0, PC_out_src=0, err_pulse=0, err_count=0, RR pointer=0, assembly register=0, all state machines to their idle state. Reset mid-packet discards the partial packet and any pending output; flits already popped are lost.
- Assembly FSM:
  - ARB: select the first lane with !isempty, scanning from the RR pointer upward with wrap. Register lane and flit index 0, then go to ASM next cycle (1-cycle bubble). No pop occurs in ARB.
  - ASM: rdreq[lane] = !isempty[lane] && !(tail && hold_full). Each pop writes its payload to slot idx and increments idx.
    - Popped flit with tail=1: load the hold buffer with the word (unused upper slots zero), src=lane. Set RR pointer = lane+1 mod NUM_IN, go to ARB.
    - Pop at idx=NFLITS-1 with tail=0: overlong. Assert err_pulse next cycle, err_count+1 saturating at all-ones, discard the word, go to DRAIN.
  - DRAIN: pop the lane while !isempty until and including a tail flit. Then advance RR pointer, go to ARB. No output is produced.
  - An empty input mid-packet stalls ASM or DRAIN indefinitely. The lane stays locked (wormhole); other lanes are not served.
- Output FSM (4-phase on a):
  - O_IDLE: if hold buffer full, move it to d/PC_out_src, v=1 next cycle, free the hold buffer, go to O_V.
  - O_V: hold v=1, d stable until a=1. Then v=0 next cycle, go to O_WAITLOW.
  - O_WAITLOW: wait a=0, then return to O_IDLE.
- Latency: tail popped at cycle t with output idle gives v=1 at t+2 (hold at t+1, d at t+2).
- Backpressure: at most one packet in the hold buffer plus one in d. A tail flit is not popped while the hold buffer is full and not being freed that cycle.
- Simultaneous events: a hold-buffer load and a free in the same cycle are legal and keep it full. err_pulse and a v change in the same cycle are independent.
- NUM_IN=1: arbitration is trivial; PC_out_src is tied to 0.

Decomposition:
- Package bz_pkg: W, NFLITS computation function, flit struct {tail, payload}, assembly FSM enum {ARB, ASM, DRAIN}, output FSM enum {O_IDLE, O_V, O_WAITLOW}.
- Sub-module bz_rr_arbiter: NUM_IN-wide round-robin priority select with registered pointer and an advance input.
- The top level contains the assembly FSM, hold buffer, output channel FSM and error counter.

Test Plan (defaults, NUM_IN=2; a follows v by one registered cycle):
- Lane0 flits 0x001, 0x002, 0x003, tail 0x003 -> one transfer d=0xC0300801, src=0, err_pulse never asserted.
- Lane1 single tail flit 0x15C -> d=0x0000015C, src=1; then lane0 single 0x0AA -> d=0x000000AA, src=0.
- Both lanes hold three single-flit packets each (lane0 0x0AA, lane1 0x155) -> outputs alternate src 0,1,0,1,0,1 with matching data, no starvation.
- Lane0 sends five flits 0x011..0x015 with tail only on the fifth, then tail packet 0x077 -> err_pulse for exactly 1 cycle, err_count=1, one output d=0x00000077; the overlong packet produces no output.
- Force a=0 for 50 cycles with 4 queued packets -> v stays 1, d stable, exactly one further packet held, no tail pop while the hold buffer is full; releasing a delivers all in order.
- Assert reset after 2 flits of a 4-flit packet, then send a new single tail flit 0x005 -> all outputs return to reset values; only d=0x00000005 is delivered.

Source files
------------

// File: rtl/bz_pkg.sv
// Shared types and sizing helpers for the BZ flit deserializer.
//   W       : output word width at default parameters
//   NFLITS  : flits needed to fill one output word
//   flit_t  : {tail, payload} layout of one input flit
package bz_pkg;

    localparam int unsigned NPC_CODE = 8;
    localparam int unsigned NPC_DATA = 24;
    localparam int unsigned NBD_DATA = 10;
    localparam int unsigned W        = NPC_CODE + NPC_DATA;

    // Number of flits required to cover a w-bit word with nb-bit payloads.
    function automatic int unsigned nflits_f(input int unsigned w, input int unsigned nb);
        return (w + nb - 1) / nb;
    endfunction

    localparam int unsigned NFLITS = nflits_f(W, NBD_DATA);

    typedef struct packed {
        logic                tail;
        logic [NBD_DATA-1:0] payload;
    } flit_t;

    typedef enum logic [1:0] {ARB, ASM, DRAIN} asm_state_e;

    typedef enum logic [1:0] {O_IDLE, O_V, O_WAITLOW} out_state_e;

endpackage

// File: rtl/bz_rr_arbiter.sv
// Round-robin lane select with a registered priority pointer.
//   clk, reset     : clock, synchronous active-high reset
//   req_i          : per-lane request (FIFO not empty)
//   advance_i      : move pointer to lane_i+1 (mod NUM_IN)
//   lane_i         : lane that just finished a packet
//   grant_o        : first requesting lane at or above the pointer (combinational)
//   grant_valid_o  : some lane is requesting (combinational)
module bz_rr_arbiter #(
    parameter int unsigned NUM_IN = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_IN-1:0]                             req_i,
    input  logic                                          advance_i,
    input  logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] lane_i,
    output logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] grant_o,
    output logic                                          grant_valid_o
);

    localparam int unsigned SW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [SW-1:0] ptr_q, ptr_d;

    // Scan from the pointer upward with wrap; first requester wins.
    always_comb begin
        int unsigned   s;
        logic [SW-1:0] idx;
        grant_o       = '0;
        grant_valid_o = 1'b0;
        s             = 0;
        idx           = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            s = 32'(ptr_q) + i;
            if (s >= NUM_IN) s = s - NUM_IN;
            idx = SW'(s);
            if (!grant_valid_o && req_i[idx]) begin
                grant_o       = idx;
                grant_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (lane_i == SW'(NUM_IN - 1)) ? '0 : SW'(lane_i + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bz_deserializer_rr.sv
// Reassembles wormhole flit packets from NUM_IN show-ahead FIFOs into one
// output word, with packet-granular round-robin, overlong drop and a
// hold buffer that overlaps assembly with the 4-phase output handshake.
//   clk, reset        : clock, synchronous active-high reset
//   isempty, data_in  : per-FIFO empty flag and head flit {tail, payload}
//   rdreq             : per-FIFO pop (one-hot or zero)
//   PC_out_channel_*  : output channel, v/d driven, a received
//   PC_out_src        : source lane of d
//   err_pulse         : one-cycle pulse per overlong packet
//   err_count         : saturating overlong-packet count
module bz_deserializer_rr
    import bz_pkg::*;
#(
    parameter int unsigned NPCcode = 8,
    parameter int unsigned NPCdata = 24,
    parameter int unsigned NBDdata = 10,
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned NERR    = 16
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_IN-1:0]                              isempty,
    input  logic [NUM_IN-1:0][NBDdata:0]                   data_in,
    output logic [NUM_IN-1:0]                              rdreq,
    output logic                                           PC_out_channel_v,
    input  logic                                           PC_out_channel_a,
    output logic [NPCcode+NPCdata-1:0]                     PC_out_channel_d,
    output logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] PC_out_src,
    output logic                                           err_pulse,
    output logic [NERR-1:0]                                err_count
);

    localparam int unsigned OW = NPCcode + NPCdata;
    localparam int unsigned NF = nflits_f(OW, NBDdata);
    localparam int unsigned AW = NF * NBDdata;
    localparam int unsigned SW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned IW = (NF > 1) ? $clog2(NF) : 1;

    asm_state_e      st_q, st_d;
    logic [SW-1:0]   lane_q, lane_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   asm_q, asm_d;
    logic            hold_full_q, hold_full_d;
    logic [OW-1:0]   hold_word_q, hold_word_d;
    logic [SW-1:0]   hold_src_q, hold_src_d;
    out_state_e      ost_q, ost_d;
    logic            v_q, v_d;
    logic [OW-1:0]   d_q, d_d;
    logic [SW-1:0]   src_q, src_d;
    logic            err_pulse_q, err_pulse_d;
    logic [NERR-1:0] err_cnt_q, err_cnt_d;

    logic [NUM_IN-1:0]  rdreq_c;
    logic [NBDdata:0]   cur_c;
    logic               cur_tail_c;
    logic [NBDdata-1:0] cur_pay_c;
    logic               hold_free_c, tail_block_c, load_c, adv_c;
    logic [SW-1:0]      grant_c;
    logic               grant_valid_c;

    bz_rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_i         (~isempty),
        .advance_i     (adv_c),
        .lane_i        (lane_q),
        .grant_o       (grant_c),
        .grant_valid_o (grant_valid_c)
    );

    assign cur_c      = data_in[lane_q];
    assign cur_tail_c = cur_c[NBDdata];
    assign cur_pay_c  = cur_c[NBDdata-1:0];

    // Hold buffer drains into d this cycle, so a tail may refill it.
    assign hold_free_c  = (ost_q == O_IDLE) && hold_full_q;
    assign tail_block_c = cur_tail_c && hold_full_q && !hold_free_c;

    // Assembly FSM: arbitrate, collect flits, or drain an overlong packet.
    always_comb begin
        st_d        = st_q;
        lane_d      = lane_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        rdreq_c     = '0;
        load_c      = 1'b0;
        adv_c       = 1'b0;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (st_q)
            ARB: begin
                if (grant_valid_c) begin
                    lane_d = grant_c;
                    idx_d  = '0;
                    asm_d  = '0;
                    st_d   = ASM;
                end
            end
            ASM: begin
                if (!isempty[lane_q] && !tail_block_c) begin
                    rdreq_c[lane_q]                          = 1'b1;
                    asm_d[int'(idx_q) * NBDdata +: NBDdata] = cur_pay_c;
                    idx_d                                    = IW'(idx_q + 1'b1);
                    if (cur_tail_c) begin
                        load_c = 1'b1;
                        adv_c  = 1'b1;
                        st_d   = ARB;
                    end else if (idx_q == IW'(NF - 1)) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + NERR'(1);
                        st_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!isempty[lane_q]) begin
                    rdreq_c[lane_q] = 1'b1;
                    if (cur_tail_c) begin
                        adv_c = 1'b1;
                        st_d  = ARB;
                    end
                end
            end
            default: st_d = ARB;
        endcase
    end

    // Hold buffer and 4-phase output channel.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_word_d = hold_word_q;
        hold_src_d  = hold_src_q;
        ost_d       = ost_q;
        v_d         = v_q;
        d_d         = d_q;
        src_d       = src_q;
        if (hold_free_c) hold_full_d = 1'b0;
        if (load_c) begin
            hold_full_d = 1'b1;
            hold_word_d = asm_d[OW-1:0];
            hold_src_d  = lane_q;
        end
        case (ost_q)
            O_IDLE: begin
                if (hold_full_q) begin
                    d_d   = hold_word_q;
                    src_d = hold_src_q;
                    v_d   = 1'b1;
                    ost_d = O_V;
                end
            end
            O_V: begin
                if (PC_out_channel_a) begin
                    v_d   = 1'b0;
                    ost_d = O_WAITLOW;
                end
            end
            O_WAITLOW: begin
                if (!PC_out_channel_a) ost_d = O_IDLE;
            end
            default: ost_d = O_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= ARB;
            lane_q      <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            hold_full_q <= 1'b0;
            hold_word_q <= '0;
            hold_src_q  <= '0;
            ost_q       <= O_IDLE;
            v_q         <= 1'b0;
            d_q         <= '0;
            src_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            st_q        <= st_d;
            lane_q      <= lane_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            hold_full_q <= hold_full_d;
            hold_word_q <= hold_word_d;
            hold_src_q  <= hold_src_d;
            ost_q       <= ost_d;
            v_q         <= v_d;
            d_q         <= d_d;
            src_q       <= src_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Pops are combinational on the show-ahead head; suppressed in reset.
    assign rdreq            = reset ? '0 : rdreq_c;
    assign PC_out_channel_v = v_q;
    assign PC_out_channel_d = d_q;
    assign PC_out_src       = (NUM_IN == 1) ? '0 : src_q;
    assign err_pulse        = err_pulse_q;
    assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_bz_deserializer_rr.sv
// Directed bench: FIFO models feed the DUT, a packet-level model rebuilds
// expected words from popped flits, and a per-cycle monitor compares.
module tb_bz_deserializer_rr;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      isempty = 2'b11;
    logic [1:0][10:0] data_in = '0;
    logic [1:0]      rdreq;
    logic            v;
    logic            a = 1'b0;
    logic [31:0]     d;
    logic [0:0]      src;
    logic            err_pulse;
    logic [15:0]     err_count;

    bz_deserializer_rr dut (
        .clk              (clk),
        .reset            (reset),
        .isempty          (isempty),
        .data_in          (data_in),
        .rdreq            (rdreq),
        .PC_out_channel_v (v),
        .PC_out_channel_a (a),
        .PC_out_channel_d (d),
        .PC_out_src       (src),
        .err_pulse        (err_pulse),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [10:0] fq0[$];
    logic [10:0] fq1[$];

    // Packet-level model state
    bit          in_pkt, draining, err_pend, pv, hold_a;
    int          cur_lane, nflit, m_cnt, completed, rises, err_hi, tot_pops;
    logic [63:0] word;
    logic [31:0] expq_d[$];
    int          expq_s[$];
    logic [31:0] log_d[$];
    int          log_s[$];
    logic [31:0] cap_d;
    logic [0:0]  cap_s;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int l, input logic [10:0] f);
        if (l == 0) fq0.push_back(f);
        else        fq1.push_back(f);
    endtask

    // Rebuild packets from the popped flit stream.
    task automatic model_pop(input int l, input logic [10:0] f);
        tot_pops++;
        if (!in_pkt) begin
            in_pkt = 1; cur_lane = l; nflit = 0; word = '0; draining = 0;
        end else begin
            chk("pop_lane_locked", 64'(l), 64'(cur_lane));
        end
        if (draining) begin
            if (f[10]) in_pkt = 0;
        end else begin
            word = word | (64'(f[9:0]) << (nflit * 10));
            nflit++;
            if (f[10]) begin
                expq_d.push_back(32'(word));
                expq_s.push_back(l);
                completed++;
                in_pkt = 0;
            end else if (nflit == 4) begin
                err_pend = 1;
                if (m_cnt < 65535) m_cnt++;
                draining = 1;
            end
        end
    endtask

    // Per-cycle monitor, FIFO driver and handshake responder.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_pkt = 0; draining = 0; err_pend = 0; pv = 0;
                m_cnt = 0; completed = 0; rises = 0;
                expq_d.delete(); expq_s.delete();
                a = 1'b0; isempty = 2'b11; data_in = '0;
            end else begin
                chk("err_pulse", 64'(err_pulse), 64'(err_pend));
                err_pend = 0;
                if (err_pulse) err_hi++;
                chk("err_count", 64'(err_count), 64'(m_cnt));
                if (v && !pv) begin
                    if (expq_d.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_v: got d=0x%0h with no packet expected", d);
                    end else begin
                        chk("out_d", 64'(d), 64'(expq_d.pop_front()));
                        chk("out_src", 64'(src), 64'(expq_s.pop_front()));
                    end
                    log_d.push_back(d); log_s.push_back(int'(src));
                    cap_d = d; cap_s = src; rises++;
                end else if (v && pv) begin
                    chk("d_stable", 64'(d), 64'(cap_d));
                    chk("src_stable", 64'(src), 64'(cap_s));
                end
                pv = v;
                chk("outstanding_le1", 64'((completed - rises > 1) ? 1 : 0), 64'(0));
                a = hold_a ? 1'b0 : v;
                isempty[0] = (fq0.size() == 0);
                isempty[1] = (fq1.size() == 0);
                data_in[0] = (fq0.size() != 0) ? fq0[0] : 11'h0;
                data_in[1] = (fq1.size() != 0) ? fq1[0] : 11'h0;
                #1;
                chk("rdreq_onehot", 64'(($countones(rdreq) <= 1) ? 1 : 0), 64'(1));
                for (int l = 0; l < 2; l++) begin
                    if (rdreq[l]) begin
                        if (isempty[l]) begin
                            n_cmp++; n_fail++;
                            $display("FAIL pop_empty: lane %0d popped while empty", l);
                        end else if (l == 0) begin
                            model_pop(0, fq0.pop_front());
                        end else begin
                            model_pop(1, fq1.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        fq0.delete(); fq1.delete();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdreq", 64'(rdreq), 64'(0));
        chk("rst_v", 64'(v), 64'(0));
        chk("rst_d", 64'(d), 64'(0));
        chk("rst_src", 64'(src), 64'(0));
        chk("rst_err_pulse", 64'(err_pulse), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #2;
            if (fq0.size() == 0 && fq1.size() == 0 && expq_d.size() == 0 &&
                !v && !a && !in_pkt) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #2;
        chk("drain_timeout", 64'(ok), 64'(1));
    endtask

    task automatic start_test();
        log_d.delete(); log_s.delete();
        err_hi = 0; tot_pops = 0;
    endtask

    initial begin
        hold_a = 0;
        do_reset();

        // Four-flit packet on lane 0
        start_test();
        push(0, 11'h001); push(0, 11'h002); push(0, 11'h003); push(0, 11'h403);
        wait_done(200);
        chk("t1_count", 64'(log_d.size()), 64'(1));
        if (log_d.size() >= 1) begin
            chk("t1_d", 64'(log_d[0]), 64'h0000_0000_C030_0801);
            chk("t1_src", 64'(log_s[0]), 64'(0));
        end
        chk("t1_no_err", 64'(err_hi), 64'(0));

        // Single-flit packets, lane 1 then lane 0
        start_test();
        push(1, 11'h55C);
        wait_done(200);
        push(0, 11'h4AA);
        wait_done(200);
        chk("t2_count", 64'(log_d.size()), 64'(2));
        if (log_d.size() >= 2) begin
            chk("t2_d0", 64'(log_d[0]), 64'h15C);
            chk("t2_s0", 64'(log_s[0]), 64'(1));
            chk("t2_d1", 64'(log_d[1]), 64'h0AA);
            chk("t2_s1", 64'(log_s[1]), 64'(0));
        end

        // Both lanes loaded: strict alternation from pointer 0
        do_reset();
        start_test();
        for (int i = 0; i < 3; i++) begin
            push(0, 11'h4AA);
            push(1, 11'h555);
        end
        wait_done(400);
        chk("t3_count", 64'(log_d.size()), 64'(6));
        for (int i = 0; i < 6 && i < log_d.size(); i++) begin
            chk("t3_src", 64'(log_s[i]), 64'(i % 2));
            chk("t3_d", 64'(log_d[i]), (i % 2 == 0) ? 64'h0AA : 64'h155);
        end

        // Overlong packet drained, then a good packet
        do_reset();
        start_test();
        push(0, 11'h011); push(0, 11'h012); push(0, 11'h013); push(0, 11'h014);
        push(0, 11'h415); push(0, 11'h477);
        wait_done(300);
        chk("t4_err_hi", 64'(err_hi), 64'(1));
        chk("t4_err_count", 64'(err_count), 64'(1));
        chk("t4_count", 64'(log_d.size()), 64'(1));
        if (log_d.size() >= 1) begin
            chk("t4_d", 64'(log_d[0]), 64'h77);
            chk("t4_src", 64'(log_s[0]), 64'(0));
        end

        // Backpressure: a held low with four queued packets
        start_test();
        hold_a = 1;
        for (int i = 1; i <= 4; i++) push(0, 11'(32'h400 + i));
        repeat (50) @(posedge clk);
        #2;
        chk("t5_v_held", 64'(v), 64'(1));
        chk("t5_one_out", 64'(log_d.size()), 64'(1));
        chk("t5_d_held", 64'(d), 64'h1);
        chk("t5_fifo_left", 64'(fq0.size()), 64'(2));
        hold_a = 0;
        wait_done(400);
        chk("t5_count", 64'(log_d.size()), 64'(4));
        for (int i = 0; i < 4 && i < log_d.size(); i++)
            chk("t5_order", 64'(log_d[i]), 64'(i + 1));

        // Reset in the middle of a packet
        start_test();
        push(0, 11'h001); push(0, 11'h002); push(0, 11'h003); push(0, 11'h404);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            if (tot_pops >= 2) break;
        end
        chk("t6_pops", 64'(tot_pops), 64'(2));
        do_reset();
        start_test();
        push(0, 11'h405);
        wait_done(200);
        chk("t6_count", 64'(log_d.size()), 64'(1));
        if (log_d.size() >= 1) begin
            chk("t6_d", 64'(log_d[0]), 64'h5);
            chk("t6_src", 64'(log_s[0]), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
